// File: rtl/shadow_ctrl_pkg.sv
// Shared types, region bounds and shadow decode for the slow-RAM shadow controller.
package shadow_ctrl_pkg;

  localparam int unsigned BANK_W   = 8;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SHADOW_W = 8;
  localparam int unsigned SADDR_W  = 17;
  localparam int unsigned LEVEL_W  = 5;

  localparam logic [BANK_W-1:0] BANK_00 = 8'h00;
  localparam logic [BANK_W-1:0] BANK_01 = 8'h01;
  localparam logic [BANK_W-1:0] BANK_E0 = 8'hE0;
  localparam logic [BANK_W-1:0] BANK_E1 = 8'hE1;

  localparam logic [ADDR_W-1:0] TEXT1_LO  = 16'h0400;
  localparam logic [ADDR_W-1:0] TEXT1_HI  = 16'h07FF;
  localparam logic [ADDR_W-1:0] TEXT2_LO  = 16'h0800;
  localparam logic [ADDR_W-1:0] TEXT2_HI  = 16'h0BFF;
  localparam logic [ADDR_W-1:0] HIRES1_LO = 16'h2000;
  localparam logic [ADDR_W-1:0] HIRES1_HI = 16'h3FFF;
  localparam logic [ADDR_W-1:0] HIRES2_LO = 16'h4000;
  localparam logic [ADDR_W-1:0] HIRES2_HI = 16'h5FFF;
  localparam logic [ADDR_W-1:0] SHR_LO    = 16'h2000;
  localparam logic [ADDR_W-1:0] SHR_HI    = 16'h9FFF;

  localparam int unsigned SH_TEXT1  = 0;
  localparam int unsigned SH_HIRES1 = 1;
  localparam int unsigned SH_HIRES2 = 2;
  localparam int unsigned SH_SHR    = 3;
  localparam int unsigned SH_AUX    = 4;
  localparam int unsigned SH_TEXT2  = 5;

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT_SLOT, DIRECT} state_e;

  typedef struct packed {
    logic              bank0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } shadow_entry_t;

  localparam int unsigned ENTRY_W = $bits(shadow_entry_t);

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Bank 01 hires pages also honour aux-hires; SHR window covers bank 01 only.
  function automatic logic is_shadowed(input logic [BANK_W-1:0]   bank,
                                       input logic [ADDR_W-1:0]   addr,
                                       input logic [SHADOW_W-1:0] shadow);
    logic b00;
    logic b01;
    logic aux_ok;
    logic hit;
    b00    = (bank == BANK_00);
    b01    = (bank == BANK_01);
    aux_ok = b00 || !shadow[SH_AUX];
    hit    = (in_range(addr, TEXT1_LO, TEXT1_HI) && !shadow[SH_TEXT1])
          || (in_range(addr, TEXT2_LO, TEXT2_HI) && !shadow[SH_TEXT2])
          || (in_range(addr, HIRES1_LO, HIRES1_HI) && !shadow[SH_HIRES1] && aux_ok)
          || (in_range(addr, HIRES2_LO, HIRES2_HI) && !shadow[SH_HIRES2] && aux_ok)
          || (b01 && in_range(addr, SHR_LO, SHR_HI) && !shadow[SH_SHR]);
    return (b00 || b01) && hit;
  endfunction

endpackage

// File: rtl/shadow_ctrl_if.sv
// CPU-side request and slow-RAM side bus of the shadow controller.
interface shadow_ctrl_if;
  import shadow_ctrl_pkg::*;

  logic                cpu_ce;
  logic [BANK_W-1:0]   bank;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   dout;
  logic                we;
  logic [SHADOW_W-1:0] shadow;
  logic                cpu_stall;
  logic                sram_ce;
  logic                sram_wr;
  logic [SADDR_W-1:0]  sram_addr;
  logic [DATA_W-1:0]   sram_din;
  logic [LEVEL_W-1:0]  fifo_level;

  modport master (
    output cpu_ce, bank, addr, dout, we, shadow,
    input  cpu_stall, sram_ce, sram_wr, sram_addr, sram_din, fifo_level
  );

  modport slave (
    input  cpu_ce, bank, addr, dout, we, shadow,
    output cpu_stall, sram_ce, sram_wr, sram_addr, sram_din, fifo_level
  );
endinterface

// File: rtl/shadow_ctrl_fifo.sv
// Synchronous FIFO with occupancy output; push into a full FIFO is accepted only alongside a pop.
module shadow_fifo
  import shadow_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   dout,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LEVEL_W'(1);
    else if (do_pop && !do_push) level_d = level_q - LEVEL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/shadow_ctrl.sv
// Shadows CPU video writes into slow RAM at the slot rate and serialises direct E0/E1 accesses behind them.
module shadow_ctrl
  import shadow_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SLOW_DIV   = 14
) (
  input  logic         clk_sys,
  input  logic         reset,
  shadow_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W     = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOW_DIV - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  shadow_entry_t       pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  shadow_entry_t       dir_q, dir_d;
  logic                dir_we_q, dir_we_d;
  logic                cpu_stall_q, cpu_stall_d;
  logic                sram_ce_q, sram_ce_d;
  logic                sram_wr_q, sram_wr_d;
  logic [SADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_din_q, sram_din_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  shadow_entry_t       fifo_din, fifo_dout;
  logic [LEVEL_W-1:0]  fifo_level;

  logic                slot_edge, shadow_wr, direct_req;
  shadow_entry_t       cpu_entry;

  always_comb begin
    slot_edge       = (cnt_q == SLOT_LAST);
    cpu_entry.bank0 = bus.bank[0];
    cpu_entry.addr  = bus.addr;
    cpu_entry.data  = bus.dout;
    shadow_wr       = bus.cpu_ce && bus.we && is_shadowed(bus.bank, bus.addr, bus.shadow);
    direct_req      = bus.cpu_ce && ((bus.bank == BANK_E0) || (bus.bank == BANK_E1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = slot_edge ? '0 : cnt_q + CNT_W'(1);
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    dir_d       = dir_q;
    dir_we_d    = dir_we_q;
    sram_ce_d   = 1'b0;
    sram_wr_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    fifo_push   = 1'b0;
    fifo_din    = cpu_entry;
    // WAIT_SLOT owns its slot for the direct access, so no drain there.
    fifo_pop    = slot_edge && !fifo_empty && (state_q != WAIT_SLOT);

    if (fifo_pop) begin
      sram_ce_d   = 1'b1;
      sram_wr_d   = 1'b1;
      sram_addr_d = {fifo_dout.bank0, fifo_dout.addr};
      sram_din_d  = fifo_dout.data;
    end

    // A parked entry only exists while the CPU is stalled, so it never races a new write.
    if (pend_vld_q) begin
      fifo_din = pend_q;
      if (!fifo_full || fifo_pop) begin
        fifo_push  = 1'b1;
        pend_vld_d = 1'b0;
      end
    end else if (shadow_wr) begin
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        pend_d     = cpu_entry;
        pend_vld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (direct_req) begin
          dir_d    = cpu_entry;
          dir_we_d = bus.we;
          state_d  = (!fifo_empty || pend_vld_q) ? DRAIN : WAIT_SLOT;
        end
      end
      DRAIN: begin
        if (fifo_empty && !pend_vld_q) state_d = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (slot_edge) begin
          state_d     = DIRECT;
          sram_ce_d   = 1'b1;
          sram_wr_d   = dir_we_q;
          sram_addr_d = {dir_q.bank0, dir_q.addr};
          sram_din_d  = dir_q.data;
        end
      end
      DIRECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cpu_stall_d = pend_vld_d || (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      dir_q       <= '0;
      dir_we_q    <= 1'b0;
      cpu_stall_q <= 1'b0;
      sram_ce_q   <= 1'b0;
      sram_wr_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      dir_q       <= dir_d;
      dir_we_q    <= dir_we_d;
      cpu_stall_q <= cpu_stall_d;
      sram_ce_q   <= sram_ce_d;
      sram_wr_q   <= sram_wr_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

  shadow_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cpu_stall  = cpu_stall_q;
  assign bus.sram_ce    = sram_ce_q;
  assign bus.sram_wr    = sram_wr_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_din   = sram_din_q;
  assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_shadow_ctrl.sv
// Bench for shadow_ctrl: decode vector table plus queue-full, drain-ordering, direct-access and reset sequences.
module tb_shadow_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV   = 14;

  typedef struct {
    logic [7:0]  bank;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  shadow;
    logic        exp_push;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  din;
  } exp_t;

  logic   clk_sys;
  logic   reset;
  exp_t   exp_q[$];
  vec_t   vecs[26];
  int     n_vec;
  int     n_err;

  shadow_ctrl_if bus();

  shadow_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .SLOW_DIV   (DIV)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [16:0] addr, input logic [7:0] din);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.din  = din;
    exp_q.push_back(e);
  endtask

  // One CPU cycle, driven at a falling edge and held across the next rising edge.
  task automatic cpu_op(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.cpu_ce = 1'b1;
    bus.bank   = b;
    bus.addr   = a;
    bus.dout   = d;
    bus.we     = w;
    @(negedge clk_sys);
    bus.cpu_ce = 1'b0;
    bus.we     = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!bus.cpu_stall && bus.fifo_level == 5'd0 && exp_q.size() == 0) return;
      @(negedge clk_sys);
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Returns on the falling edge right after a drain pulse, i.e. at the start of a slot.
  task automatic sync_slot();
    bit found;
    found = 1'b0;
    wait_idle();
    bus.shadow = 8'h00;
    push_exp(1'b1, 17'h00400, 8'hA5);
    cpu_op(8'h00, 16'h0400, 8'hA5, 1'b1);
    for (int i = 0; i < 3 * DIV; i++) begin
      if (bus.sram_ce) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("sync_slot_seen", 32'(found), 32'd1);
  endtask

  // Scoreboard: every slow-RAM strobe must match the oldest expected access.
  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset && bus.sram_ce) begin
      if (exp_q.size() == 0) begin
        check("sram_unexpected_ce", {15'd0, bus.sram_addr}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sram_wr",   32'(bus.sram_wr),   32'(e.wr));
        check("sram_addr", 32'(bus.sram_addr), 32'(e.addr));
        check("sram_din",  32'(bus.sram_din),  32'(e.din));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stall_gap;
    bit   found;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{8'h00, 16'h0400, 8'h41, 1'b1, 8'h00, 1'b1};
    vecs[1]  = '{8'h00, 16'h0400, 8'h41, 1'b1, 8'h01, 1'b0};
    vecs[2]  = '{8'h00, 16'h07FF, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{8'h00, 16'h03FF, 8'h56, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 16'h0800, 8'h66, 1'b1, 8'h00, 1'b1};
    vecs[5]  = '{8'h00, 16'h0800, 8'h66, 1'b1, 8'h20, 1'b0};
    vecs[6]  = '{8'h00, 16'h0BFF, 8'h12, 1'b1, 8'h00, 1'b1};
    vecs[7]  = '{8'h00, 16'h0C00, 8'h13, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{8'h00, 16'h2000, 8'h21, 1'b1, 8'h02, 1'b0};
    vecs[9]  = '{8'h00, 16'h3FFF, 8'h22, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{8'h00, 16'h4000, 8'h23, 1'b1, 8'h04, 1'b0};
    vecs[11] = '{8'h00, 16'h5FFF, 8'h24, 1'b1, 8'h00, 1'b1};
    vecs[12] = '{8'h00, 16'h6000, 8'h25, 1'b1, 8'h00, 1'b0};
    // Aux-hires alone leaves the SHR window open in bank 01.
    vecs[13] = '{8'h01, 16'h2000, 8'hFF, 1'b1, 8'h10, 1'b1};
    vecs[14] = '{8'h01, 16'h2000, 8'hFF, 1'b1, 8'h18, 1'b0};
    vecs[15] = '{8'h01, 16'h2000, 8'hFF, 1'b1, 8'h08, 1'b1};
    vecs[16] = '{8'h01, 16'h9FFF, 8'h31, 1'b1, 8'h00, 1'b1};
    vecs[17] = '{8'h01, 16'h9FFF, 8'h32, 1'b1, 8'h08, 1'b0};
    vecs[18] = '{8'h01, 16'hA000, 8'h33, 1'b1, 8'h00, 1'b0};
    vecs[19] = '{8'h00, 16'h9FFF, 8'h34, 1'b1, 8'h00, 1'b0};
    vecs[20] = '{8'h02, 16'h0400, 8'h35, 1'b1, 8'h00, 1'b0};
    vecs[21] = '{8'h00, 16'h0400, 8'h36, 1'b0, 8'h00, 1'b0};
    vecs[22] = '{8'h01, 16'h0400, 8'h37, 1'b1, 8'h00, 1'b1};
    vecs[23] = '{8'h01, 16'h4000, 8'h38, 1'b1, 8'h0C, 1'b0};
    vecs[24] = '{8'h01, 16'h4000, 8'h39, 1'b1, 8'h08, 1'b1};
    vecs[25] = '{8'h00, 16'h4000, 8'h3A, 1'b1, 8'h10, 1'b1};

    reset      = 1'b1;
    bus.cpu_ce = 1'b0;
    bus.bank   = 8'h00;
    bus.addr   = 16'h0000;
    bus.dout   = 8'h00;
    bus.we     = 1'b0;
    bus.shadow = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    check("rst_sram_ce",    32'(bus.sram_ce),    32'd0);
    check("rst_sram_wr",    32'(bus.sram_wr),    32'd0);
    check("rst_sram_addr",  32'(bus.sram_addr),  32'd0);
    check("rst_sram_din",   32'(bus.sram_din),   32'd0);
    check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      wait_idle();
      bus.shadow = vecs[i].shadow;
      if (vecs[i].exp_push) push_exp(1'b1, {vecs[i].bank[0], vecs[i].addr}, vecs[i].data);
      cpu_op(vecs[i].bank, vecs[i].addr, vecs[i].data, vecs[i].we);
      check($sformatf("vec%0d_level", i), 32'(bus.fifo_level), vecs[i].exp_push ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_stall", i), 32'(bus.cpu_stall), 32'd0);
      repeat (DIV + 3) @(negedge clk_sys);
      check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
    end

    // Five back-to-back writes into a depth-4 queue: fifth parks and stalls until the first pop.
    sync_slot();
    for (int k = 0; k < 5; k++) begin
      push_exp(1'b1, 17'h00500 + 17'(k), 8'hC0 + 8'(k));
      cpu_op(8'h00, 16'h0500 + 16'(k), 8'hC0 + 8'(k), 1'b1);
    end
    check("full_level", 32'(bus.fifo_level), 32'd4);
    check("full_stall", 32'(bus.cpu_stall),  32'd1);
    stall_gap = 0;
    found     = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (bus.sram_ce) begin
        found = 1'b1;
        break;
      end
      if (!bus.cpu_stall) stall_gap++;
      @(negedge clk_sys);
    end
    check("full_first_pop",      32'(found),          32'd1);
    check("full_stall_held",     32'(stall_gap),      32'd0);
    check("full_stall_released", 32'(bus.cpu_stall),  32'd0);
    check("full_level_after",    32'(bus.fifo_level), 32'd4);
    wait_idle();

    // Two queued writes must reach slow RAM before the direct read of E1:2000.
    sync_slot();
    push_exp(1'b1, 17'h00600, 8'hD1);
    cpu_op(8'h00, 16'h0600, 8'hD1, 1'b1);
    push_exp(1'b1, 17'h00601, 8'hD2);
    cpu_op(8'h00, 16'h0601, 8'hD2, 1'b1);
    push_exp(1'b0, 17'h12000, 8'h5A);
    cpu_op(8'hE1, 16'h2000, 8'h5A, 1'b0);
    check("dir_rd_stall_start", 32'(bus.cpu_stall), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (bus.sram_ce && !bus.sram_wr) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("dir_rd_seen",        32'(found),         32'd1);
    check("dir_rd_stall_in",    32'(bus.cpu_stall), 32'd1);
    @(negedge clk_sys);
    check("dir_rd_stall_drop",  32'(bus.cpu_stall), 32'd0);
    check("dir_rd_queue_empty", 32'(exp_q.size()),  32'd0);

    // Direct write with an empty queue.
    wait_idle();
    push_exp(1'b1, 17'h01234, 8'h77);
    cpu_op(8'hE0, 16'h1234, 8'h77, 1'b1);
    check("dir_wr_stall_start", 32'(bus.cpu_stall), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (bus.sram_ce) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("dir_wr_seen", 32'(found), 32'd1);
    @(negedge clk_sys);
    check("dir_wr_stall_drop", 32'(bus.cpu_stall), 32'd0);

    // Reset with a full queue and a parked entry: everything is discarded.
    sync_slot();
    for (int k = 0; k < 5; k++) cpu_op(8'h00, 16'h0700 + 16'(k), 8'hE0 + 8'(k), 1'b1);
    check("pre_rst_level", 32'(bus.fifo_level), 32'd4);
    check("pre_rst_stall", 32'(bus.cpu_stall),  32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    check("mid_rst_sram_ce",    32'(bus.sram_ce),    32'd0);
    check("mid_rst_sram_wr",    32'(bus.sram_wr),    32'd0);
    check("mid_rst_sram_addr",  32'(bus.sram_addr),  32'd0);
    check("mid_rst_sram_din",   32'(bus.sram_din),   32'd0);
    check("mid_rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (3 * DIV) @(negedge clk_sys);
    check("post_rst_level", 32'(bus.fifo_level), 32'd0);
    check("post_rst_stall", 32'(bus.cpu_stall),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
